instr_mem_loader: RTL
=====================

Name: instr_mem_loader

Overview:
- Writer side of the instruction-memory fetch path: the processor reads instruction words at PC; this block writes them.
- Accepts a byte stream from a host over a valid/ready handshake and assembles 16-bit instruction words, high byte first.
- Writes each word into the instruction memory write port at consecutive addresses starting from 0.
- Holds the processor in reset for the whole load and releases it when the load completes.

Parameters:
- ADDR_W, 7, instruction memory address width (matches the 7-bit PC).
- DATA_W, 16, instruction word width (matches IR).
- DEPTH, 128, number of instruction memory words; equals 2**ADDR_W.

Ports:
- Clk  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  single-cycle pulse that begins a load; sampled only in IDLE.
- Len  input  8  number of words to load; legal range 1..DEPTH; sampled with Start.
- Byte_In  input  8  host data byte.
- Byte_Valid  input  1  host asserts when Byte_In is valid.
- Byte_Ready  output  1  loader can accept a byte; a byte transfers when Byte_Valid and Byte_Ready are both high at a rising edge.
- IM_Wr  output  1  instruction memory write enable; one-cycle pulse per word.
- IM_Addr  output  ADDR_W  instruction memory write address.
- IM_Data  output  DATA_W  instruction memory write data.
- CPU_Reset  output  1  reset to the processor; high while a load is pending or in progress.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse when the last word has been written.
- Err  output  1  sticky flag for an illegal Len; cleared by the next accepted Start.
- Checksum  output  8  XOR of all bytes accepted since the last accepted Start.

Behaviour:
- Reset values: state IDLE, Byte_Ready 0, IM_Wr 0, IM_Addr 0, IM_Data 0, CPU_Reset 1, Busy 0, Done 0, Err 0, Checksum 0, word counter 0. Reset takes effect immediately, independent of Clk.
- States: IDLE, GET_HI, GET_LO, WRITE, DONE. All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- IDLE, Start with 1<=Len<=DEPTH:
  - IM_Addr<=0, counter<=Len, Checksum<=0, Err<=0, CPU_Reset<=1.
  - Next state GET_HI.
- IDLE, Start with Len==0 or Len>DEPTH: Err<=1, stay in IDLE, CPU_Reset unchanged.
- GET_HI: Byte_Ready=1. On transfer, latch the high byte, Checksum^=Byte_In, go to GET_LO. Otherwise hold; stalls have no time limit.
- GET_LO: Byte_Ready=1. On transfer, IM_Data<={hi,Byte_In}, Checksum^=Byte_In, go to WRITE.
- WRITE: IM_Wr=1 for exactly this cycle, with IM_Addr and IM_Data stable. counter<=counter-1.
  - If counter was 1, go to DONE; IM_Addr holds the last address.
  - Otherwise IM_Addr<=IM_Addr+1 and go to GET_HI.
- DONE: Done=1 for one cycle, CPU_Reset<=0 (low from the next cycle onward), go to IDLE.
- Byte_Ready is 0 in IDLE, WRITE and DONE. Byte_Valid in those states is ignored and no byte is consumed.
- Throughput is at most one word per 3 cycles. Write latency: IM_Wr rises 1 cycle after the low-byte transfer edge.
- Start while Busy is ignored, with no effect on Err or Len.
- IM_Addr wraps never: with Len=DEPTH the final write is at address DEPTH-1.
- After a completed load, CPU_Reset stays 0 until the next accepted Start or Reset.
- Reset mid-load: all outputs return to reset values. Words already written stay in memory and are not cleared. CPU_Reset=1.
- IM_Data and Checksum hold their last values in IDLE.

Test Plan:
- Reset released, then idle 10 cycles -> CPU_Reset=1, Busy=0, Byte_Ready=0, IM_Wr never pulses.
- Start, Len=2, bytes 12,34,AB,CD with Byte_Valid held high -> IM_Wr pulses at addr 0 data 1234, then addr 1 data ABCD, 3 cycles apart. Done pulses once, then CPU_Reset=0, Checksum=12^34^AB^CD=40.
- Same load with Byte_Valid deasserted 5 cycles between every byte -> identical writes and Checksum. Byte_Ready stays high through the stalls. No extra IM_Wr pulses.
- Start with Len=0, then Start with Len=129 -> Err=1 after each, state stays IDLE, no writes. Then Start with Len=1 and bytes 00,01 -> Err=0, write addr 0 data 0001.
- Len=128 with incrementing words -> 128 writes, last at addr 7F. Start pulsed mid-load is ignored. Done after the 128th write.
- Start, Len=4, assert Reset after the second write -> outputs go to reset values asynchronously and CPU_Reset=1. A subsequent Len=1 load writes addr 0.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction memory: assembles 16-bit words (high byte first),
// writes them from address 0 upward, and holds the processor in reset until the load completes.
module instr_mem_loader #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        Len,
    input  logic [7:0]        Byte_In,
    input  logic              Byte_Valid,
    output logic              Byte_Ready,
    output logic              IM_Wr,
    output logic [ADDR_W-1:0] IM_Addr,
    output logic [DATA_W-1:0] IM_Data,
    output logic              CPU_Reset,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [7:0]        Checksum,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GET_HI = 3'd1;
    localparam logic [2:0] S_GET_LO = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [8:0] DEPTH_L = 9'(DEPTH);

    logic [2:0] state;
    logic [7:0] hi_byte;
    logic [7:0] counter;
    logic       len_ok;
    logic       byte_xfer;

    // Handshake: a byte moves on a rising edge where Byte_Valid and Byte_Ready are both high;
    // Byte_Ready depends only on state, so the host may hold Byte_Valid high across any stall.
    assign Byte_Ready = (state == S_GET_HI) || (state == S_GET_LO);
    assign byte_xfer  = Byte_Valid && Byte_Ready;
    assign IM_Wr      = (state == S_WRITE);
    assign Busy       = (state != S_IDLE);
    assign Done       = (state == S_DONE);
    assign dbg_state  = state;

    assign len_ok = (Len != 8'd0) && ({1'b0, Len} <= DEPTH_L);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            hi_byte   <= 8'd0;
            counter   <= 8'd0;
            IM_Addr   <= '0;
            IM_Data   <= '0;
            CPU_Reset <= 1'b1;
            Err       <= 1'b0;
            Checksum  <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (len_ok) begin
                            IM_Addr   <= '0;
                            counter   <= Len;
                            Checksum  <= 8'd0;
                            Err       <= 1'b0;
                            CPU_Reset <= 1'b1;
                            state     <= S_GET_HI;
                        end else begin
                            Err <= 1'b1;
                        end
                    end
                end
                S_GET_HI: begin
                    if (byte_xfer) begin
                        hi_byte  <= Byte_In;
                        Checksum <= Checksum ^ Byte_In;
                        state    <= S_GET_LO;
                    end
                end
                S_GET_LO: begin
                    if (byte_xfer) begin
                        IM_Data  <= DATA_W'({hi_byte, Byte_In});
                        Checksum <= Checksum ^ Byte_In;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    counter <= counter - 8'd1;
                    // The last word keeps its address so IM_Addr never wraps past DEPTH-1.
                    if (counter == 8'd1) begin
                        state <= S_DONE;
                    end else begin
                        IM_Addr <= IM_Addr + 1'b1;
                        state   <= S_GET_HI;
                    end
                end
                S_DONE: begin
                    CPU_Reset <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
